// File: rtl/mips_pkg.sv
// Shared ISA constants, decoded-instruction struct, and the per-slot decode and ALU functions
// for the two-wide in-order MIPS-32 core.
package mips_pkg;

  localparam int NUM_SLOTS = 2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic        we;
    logic        is_mem;
    logic        is_ctrl;
    logic        is_alu;   // eligible for slot 1
    alu_op_e     op;
    logic        src_imm;
    logic        rd_rs;    // rs is a true source operand
    logic        rd_rt;    // rt is a true source operand
    logic        is_lw;
    logic        is_sw;
    logic        is_beq;
    logic        is_bne;
    logic        is_j;
    logic        is_jal;
    logic        is_jr;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d;
    d       = '0;
    d.rs    = ins[25:21];
    d.rt    = ins[20:16];
    d.rd    = ins[15:11];
    d.shamt = ins[10:6];
    d.imm   = {{16{ins[15]}}, ins[15:0]};
    d.op    = ALU_ADD;
    case (ins[31:26])
      OP_RTYPE: begin
        d.is_alu = 1'b1; d.we = 1'b1; d.dest = ins[15:11];
        d.rd_rs  = 1'b1; d.rd_rt = 1'b1;
        case (ins[5:0])
          FN_ADD, FN_ADDU: d.op = ALU_ADD;
          FN_SUB, FN_SUBU: d.op = ALU_SUB;
          FN_AND:  d.op = ALU_AND;
          FN_OR:   d.op = ALU_OR;
          FN_XOR:  d.op = ALU_XOR;
          FN_NOR:  d.op = ALU_NOR;
          FN_SLT:  d.op = ALU_SLT;
          FN_SLTU: d.op = ALU_SLTU;
          FN_SLL:  begin d.op = ALU_SLL; d.rd_rs = 1'b0; end
          FN_SRL:  begin d.op = ALU_SRL; d.rd_rs = 1'b0; end
          FN_SRA:  begin d.op = ALU_SRA; d.rd_rs = 1'b0; end
          FN_JR: begin
            d.is_alu = 1'b0; d.we = 1'b0; d.rd_rt = 1'b0;
            d.is_ctrl = 1'b1; d.is_jr = 1'b1;
          end
          default: begin
            d.is_alu = 1'b0; d.we = 1'b0; d.rd_rs = 1'b0; d.rd_rt = 1'b0;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        d.is_alu = 1'b1; d.we = 1'b1; d.dest = ins[20:16];
        d.src_imm = 1'b1; d.rd_rs = (ins[31:26] != OP_LUI);
        case (ins[31:26])
          OP_SLTI:  d.op = ALU_SLT;
          OP_SLTIU: d.op = ALU_SLTU;
          OP_ANDI:  begin d.op = ALU_AND; d.imm = {16'h0, ins[15:0]}; end
          OP_ORI:   begin d.op = ALU_OR;  d.imm = {16'h0, ins[15:0]}; end
          OP_XORI:  begin d.op = ALU_XOR; d.imm = {16'h0, ins[15:0]}; end
          OP_LUI:   d.op = ALU_LUI;
          default:  d.op = ALU_ADD;
        endcase
      end
      OP_LW: begin
        d.is_mem = 1'b1; d.is_lw = 1'b1; d.we = 1'b1; d.dest = ins[20:16];
        d.src_imm = 1'b1; d.rd_rs = 1'b1;
      end
      OP_SW: begin
        d.is_mem = 1'b1; d.is_sw = 1'b1; d.src_imm = 1'b1;
        d.rd_rs = 1'b1; d.rd_rt = 1'b1;
      end
      OP_BEQ: begin d.is_ctrl = 1'b1; d.is_beq = 1'b1; d.rd_rs = 1'b1; d.rd_rt = 1'b1; end
      OP_BNE: begin d.is_ctrl = 1'b1; d.is_bne = 1'b1; d.rd_rs = 1'b1; d.rd_rt = 1'b1; end
      OP_J:   begin d.is_ctrl = 1'b1; d.is_j = 1'b1; end
      OP_JAL: begin d.is_ctrl = 1'b1; d.is_jal = 1'b1; d.we = 1'b1; d.dest = 5'd31; end
      default: ;
    endcase
    // $0 is hard-wired, so a write to it is simply dropped.
    if (d.dest == 5'd0) d.we = 1'b0;
    return d;
  endfunction

  function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a,
                                      input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] r;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_NOR:  r = ~(a | b);
      ALU_SLT:  r = {31'h0, $signed(a) < $signed(b)};
      ALU_SLTU: r = {31'h0, a < b};
      ALU_SLL:  r = b << sh;
      ALU_SRL:  r = b >> sh;
      ALU_SRA:  r = $unsigned($signed(b) >>> sh);
      ALU_LUI:  r = {b[15:0], 16'h0};
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/top_ph4_mem.sv
// Word-addressed instruction and data memories; reads are combinational, writes on the clock edge.
module ph4_imem #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr0,
  input  logic [AW-1:0] raddr1,
  output logic [31:0]   rdata0,
  output logic [31:0]   rdata1
);
  logic [31:0] RAM [0:WORDS-1];

  // Load port; the core ties it off and programs arrive by preloading RAM.
  always_ff @(posedge clk) begin
    if (we) RAM[waddr] <= wdata;
  end

  assign rdata0 = RAM[raddr0];
  assign rdata1 = RAM[raddr1];
endmodule

module ph4_dmem #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] RAM [0:WORDS-1];

  always_ff @(posedge clk) begin
    if (we) RAM[addr] <= wdata;
  end

  assign rdata = RAM[addr];
endmodule

// File: rtl/top_ph4_regfile.sv
// 32 x 32-bit GPR file: four combinational read ports, two write ports committing on the same edge.
module regfile_4r2w import mips_pkg::*; #(
  parameter int RP = 2 * NUM_SLOTS,
  parameter int WP = NUM_SLOTS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RP-1:0][4:0]   ra,
  output logic [RP-1:0][31:0]  rd,
  input  logic [WP-1:0]        we,
  input  logic [WP-1:0][4:0]   wa,
  input  logic [WP-1:0][31:0]  wd
);
  logic [31:0] regs [0:31];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      for (int p = 0; p < WP; p++)
        if (we[p] && wa[p] != 5'd0) regs[wa[p]] <= wd[p];
    end
  end

  for (genvar r = 0; r < RP; r++) begin : g_rd
    assign rd[r] = (ra[r] == 5'd0) ? '0 : regs[ra[r]];
  end
endmodule

// File: rtl/top_ph4.sv
// Phase-4 two-wide in-order MIPS-32 core: slot 0 executes anything, slot 1 only an
// independent ALU op; both retire in a single cycle.
module top_ph4 import mips_pkg::*; #(
  parameter int          IM_WORDS = 256,
  parameter int          DM_WORDS = 256,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic CLK,
  input  logic CLR
);
  localparam int IAW = $clog2(IM_WORDS);
  localparam int DAW = $clog2(DM_WORDS);

  logic [31:0]                     PC, npc, pc4;
  logic [NUM_SLOTS-1:0][31:0]      ins, res, opb;
  dec_t [NUM_SLOTS-1:0]            dec;
  logic [2*NUM_SLOTS-1:0][4:0]     ra;
  logic [2*NUM_SLOTS-1:0][31:0]    rv;
  logic [NUM_SLOTS-1:0]            rf_we;
  logic [NUM_SLOTS-1:0][4:0]       rf_wa;
  logic [NUM_SLOTS-1:0][31:0]      rf_wd;
  logic [IAW-1:0]                  fidx;
  logic [31:0]                     dm_rdata;
  logic                            dual, raw, waw, eq;

  assign fidx = PC[IAW+1:2];

  ph4_imem #(.WORDS(IM_WORDS)) im (
    .clk(CLK), .we(1'b0), .waddr('0), .wdata('0),
    .raddr0(fidx), .raddr1(fidx + 1'b1),
    .rdata0(ins[0]), .rdata1(ins[1])
  );

  // Per slot: decode, two register read ports, operand select, ALU.
  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    assign dec[s]      = decode(ins[s]);
    assign ra[2*s]     = dec[s].rs;
    assign ra[2*s+1]   = dec[s].rt;
    assign opb[s]      = dec[s].src_imm ? dec[s].imm : rv[2*s+1];
    assign res[s]      = alu(dec[s].op, rv[2*s], opb[s], dec[s].shamt);
  end

  regfile_4r2w rf (
    .clk(CLK), .rst(CLR), .ra(ra), .rd(rv),
    .we(rf_we), .wa(rf_wa), .wd(rf_wd)
  );

  // Stores are suppressed during reset so memory survives a mid-run CLR.
  ph4_dmem #(.WORDS(DM_WORDS)) dm (
    .clk(CLK), .we(dec[0].is_sw & ~CLR), .addr(res[0][DAW+1:2]),
    .wdata(rv[1]), .rdata(dm_rdata)
  );

  // Pairing is only legal when slot 1 needs nothing slot 0 produces this cycle.
  assign raw  = dec[0].we && ((dec[1].rd_rs && dec[1].rs == dec[0].dest) ||
                              (dec[1].rd_rt && dec[1].rt == dec[0].dest));
  assign waw  = dec[0].we && dec[1].we && (dec[0].dest == dec[1].dest);
  assign dual = !dec[0].is_ctrl && !dec[0].is_mem && dec[1].is_alu && !raw && !waw;

  always_comb begin
    pc4 = PC + 32'd4;
    eq  = (rv[0] == rv[1]);
    npc = dual ? PC + 32'd8 : pc4;
    if ((dec[0].is_beq && eq) || (dec[0].is_bne && !eq))
      npc = pc4 + {dec[0].imm[29:0], 2'b00};
    else if (dec[0].is_j || dec[0].is_jal)
      npc = {pc4[31:28], ins[0][25:0], 2'b00};
    else if (dec[0].is_jr)
      npc = rv[0];

    rf_we[0] = dec[0].we;
    rf_wa[0] = dec[0].dest;
    rf_wd[0] = dec[0].is_lw ? dm_rdata : (dec[0].is_jal ? pc4 : res[0]);
    rf_we[1] = dual & dec[1].we;
    rf_wa[1] = dec[1].dest;
    rf_wd[1] = res[1];
  end

  always_ff @(posedge CLK) begin
    if (CLR) PC <= RESET_PC;
    else     PC <= npc;
  end
endmodule

// File: tb/tb_top_ph4.sv
// Directed bench for top_ph4: programs are preloaded through im.RAM, expectations queued and
// drained against PC, GPRs and dm.RAM.
module tb_top_ph4;
  import mips_pkg::*;

  logic CLK, CLR;
  int total = 0;
  int bad   = 0;
  int step  = 0;

  typedef struct {
    int          step;
    int          kind;   // 0 = PC, 1 = GPR, 2 = dm word
    int          idx;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  top_ph4 dut (.CLK(CLK), .CLR(CLR));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] er(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [4:0] sh,
                                     input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] ej(input logic [5:0] op, input logic [31:0] tgt);
    return {op, tgt[27:2]};
  endfunction

  function automatic string kname(input int k);
    case (k)
      0: return "pc";
      1: return "gpr";
      default: return "dm";
    endcase
  endfunction

  function automatic logic [31:0] peek(input int k, input int idx);
    case (k)
      0: return dut.PC;
      1: return dut.rf.regs[idx];
      default: return dut.dm.RAM[idx];
    endcase
  endfunction

  task automatic put(input int addr, input logic [31:0] w);
    dut.im.RAM[addr >> 2] = w;
  endtask

  task automatic clear_im();
    for (int i = 0; i < 256; i++) dut.im.RAM[i] = 32'h0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic expect_v(input int k, input int idx, input logic [31:0] v);
    exp_t e;
    e.step = step; e.kind = k; e.idx = idx; e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = peek(e.kind, e.idx);
      total++;
      assert (o === e.val) else begin
        bad++;
        $error("FAIL s%0d %s[%0d] observed=%h expected=%h", e.step, kname(e.kind), e.idx, o, e.val);
      end
    end
  endtask

  int arr [32];
  int key, j;

  initial begin
    // ---- reset, then a dual-issue pair ----
    CLR = 1'b1;
    clear_im();
    put(32'h00, ei(OP_ADDI, 5'd0, 5'd1, 16'd5));
    put(32'h04, ei(OP_ADDI, 5'd0, 5'd2, 16'd7));
    put(32'h08, ej(OP_J, 32'h08));
    tick(2);
    step = 1;
    expect_v(0, 0, 32'h0);
    for (int r = 1; r < 32; r++) expect_v(1, r, 32'h0);
    drain();
    CLR = 1'b0;
    tick(1);
    step = 2;
    expect_v(0, 0, 32'h8); expect_v(1, 1, 32'd5); expect_v(1, 2, 32'd7);
    drain();
    tick(3);
    step = 3;
    expect_v(0, 0, 32'h8);
    drain();

    // ---- RAW forces single issue; WAW too ----
    CLR = 1'b1;
    clear_im();
    put(32'h00, ei(OP_ADDI, 5'd0, 5'd1, 16'd5));
    put(32'h04, er(5'd1, 5'd1, 5'd2, 5'd0, FN_ADD));
    put(32'h08, ej(OP_J, 32'h0C));
    put(32'h0C, ei(OP_ADDI, 5'd0, 5'd4, 16'd1));
    put(32'h10, ei(OP_ADDI, 5'd0, 5'd4, 16'd2));
    put(32'h14, ej(OP_J, 32'h14));
    tick(2);
    CLR = 1'b0;
    tick(1);
    step = 4;
    expect_v(0, 0, 32'h4); expect_v(1, 1, 32'd5); expect_v(1, 2, 32'd0);
    drain();
    tick(1);
    step = 5;
    expect_v(0, 0, 32'h8); expect_v(1, 2, 32'd10);
    drain();
    tick(2);
    step = 6;
    expect_v(0, 0, 32'h10); expect_v(1, 4, 32'd1);
    drain();
    tick(3);
    step = 7;
    expect_v(0, 0, 32'h14); expect_v(1, 4, 32'd2);
    drain();

    // ---- sw/lw, branch self-loop, and reset landing on a store ----
    CLR = 1'b1;
    clear_im();
    dut.dm.RAM[32] = 32'hDEADBEEF;
    put(32'h00, ei(OP_ADDI, 5'd0, 5'd1, 16'd5));
    put(32'h04, ei(OP_SW, 5'd0, 5'd1, 16'h0080));
    put(32'h08, ei(OP_LW, 5'd0, 5'd3, 16'h0080));
    put(32'h0C, ej(OP_J, 32'h78));
    put(32'h78, ei(OP_BEQ, 5'd0, 5'd0, 16'hFFFF));
    tick(2);
    CLR = 1'b0;
    tick(1);
    step = 8;
    expect_v(0, 0, 32'h4); expect_v(1, 1, 32'd5);
    drain();
    CLR = 1'b1;
    tick(1);
    step = 9;
    expect_v(0, 0, 32'h0); expect_v(1, 1, 32'd0); expect_v(2, 32, 32'hDEADBEEF);
    drain();
    CLR = 1'b0;
    tick(8);
    step = 10;
    expect_v(0, 0, 32'h78); expect_v(2, 32, 32'd5); expect_v(1, 3, 32'd5);
    drain();

    // ---- ALU mix, jal/jr, bne taken ----
    CLR = 1'b1;
    clear_im();
    put(32'h00, ei(OP_LUI, 5'd0, 5'd1, 16'h8000));
    put(32'h04, ei(OP_ORI, 5'd0, 5'd2, 16'hFFFF));
    put(32'h08, ei(OP_ADDI, 5'd0, 5'd3, 16'hFFFD));
    put(32'h0C, er(5'd0, 5'd1, 5'd4, 5'd4, FN_SRA));
    put(32'h10, er(5'd0, 5'd1, 5'd5, 5'd4, FN_SRL));
    put(32'h14, er(5'd0, 5'd2, 5'd6, 5'd8, FN_SLL));
    put(32'h18, er(5'd2, 5'd3, 5'd7, 5'd0, FN_SUB));
    put(32'h1C, er(5'd3, 5'd0, 5'd8, 5'd0, FN_SLT));
    put(32'h20, er(5'd3, 5'd0, 5'd9, 5'd0, FN_SLTU));
    put(32'h24, er(5'd2, 5'd0, 5'd10, 5'd0, FN_NOR));
    put(32'h28, er(5'd2, 5'd6, 5'd11, 5'd0, FN_XOR));
    put(32'h2C, er(5'd2, 5'd6, 5'd12, 5'd0, FN_AND));
    put(32'h30, ei(OP_SLTIU, 5'd2, 5'd13, 16'hFFFF));
    put(32'h34, ej(OP_JAL, 32'h40));
    put(32'h38, ej(OP_J, 32'h38));
    put(32'h40, ei(OP_BNE, 5'd8, 5'd0, 16'd1));
    put(32'h44, ei(OP_ADDI, 5'd0, 5'd14, 16'd1));
    put(32'h48, er(5'd2, 5'd2, 5'd15, 5'd0, FN_ADDU));
    put(32'h4C, er(5'd31, 5'd0, 5'd0, 5'd0, FN_JR));
    tick(2);
    CLR = 1'b0;
    tick(30);
    step = 11;
    expect_v(0, 0, 32'h38);
    expect_v(1, 1, 32'h80000000); expect_v(1, 2, 32'h0000FFFF);
    expect_v(1, 3, 32'hFFFFFFFD); expect_v(1, 4, 32'hF8000000);
    expect_v(1, 5, 32'h08000000); expect_v(1, 6, 32'h00FFFF00);
    expect_v(1, 7, 32'h00010002); expect_v(1, 8, 32'd1);
    expect_v(1, 9, 32'd0);        expect_v(1, 10, 32'hFFFF0000);
    expect_v(1, 11, 32'h00FF00FF); expect_v(1, 12, 32'h0000FF00);
    expect_v(1, 13, 32'd1);       expect_v(1, 14, 32'd0);
    expect_v(1, 15, 32'h0001FFFE); expect_v(1, 31, 32'h38);
    drain();

    // ---- insertion sort of dm words 32..63, halting at 0x78 ----
    CLR = 1'b1;
    clear_im();
    for (int i = 0; i < 32; i++) begin
      arr[i] = $urandom;
      dut.dm.RAM[32 + i] = arr[i];
    end
    for (int i = 1; i < 32; i++) begin
      key = arr[i];
      j = i - 1;
      while (j >= 0 && key < arr[j]) begin
        arr[j + 1] = arr[j];
        j--;
      end
      arr[j + 1] = key;
    end
    put(32'h00, ei(OP_ADDI, 5'd0, 5'd2, 16'd4));
    put(32'h04, ei(OP_ADDI, 5'd0, 5'd9, 16'h0080));
    put(32'h08, ei(OP_BEQ, 5'd2, 5'd9, 16'd27));
    put(32'h0C, ei(OP_LW, 5'd2, 5'd3, 16'h0080));
    put(32'h10, ei(OP_ADDI, 5'd2, 5'd4, 16'hFFFC));
    put(32'h14, er(5'd4, 5'd0, 5'd5, 5'd0, FN_SLT));
    put(32'h18, ei(OP_BNE, 5'd5, 5'd0, 16'd6));
    put(32'h1C, ei(OP_LW, 5'd4, 5'd6, 16'h0080));
    put(32'h20, er(5'd3, 5'd6, 5'd7, 5'd0, FN_SLT));
    put(32'h24, ei(OP_BEQ, 5'd7, 5'd0, 16'd3));
    put(32'h28, ei(OP_SW, 5'd4, 5'd6, 16'h0084));
    put(32'h2C, ei(OP_ADDI, 5'd4, 5'd4, 16'hFFFC));
    put(32'h30, ej(OP_J, 32'h14));
    put(32'h34, ei(OP_SW, 5'd4, 5'd3, 16'h0084));
    put(32'h38, ei(OP_ADDI, 5'd2, 5'd2, 16'd4));
    put(32'h3C, ej(OP_J, 32'h08));
    put(32'h78, ej(OP_J, 32'h78));
    tick(2);
    CLR = 1'b0;
    for (int c = 0; c < 20000 && dut.PC !== 32'h78; c++) tick(1);
    tick(2);
    step = 12;
    expect_v(0, 0, 32'h78);
    for (int i = 0; i < 32; i++) expect_v(2, 32 + i, arr[i]);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
